// File: rtl/bp_me_wormhole_packet_deserializer.sv
// Receive endpoint of a ready_and wormhole link: reassembles flits into {payload, len, cord}.
// Optional protocol checking (sticky error_o) is enabled with `define BP_ME_WH_DESER_PROTOCOL_CHECK_EN.
module bp_me_wormhole_packet_deserializer #(
    parameter int flit_width_p        = 16,
    parameter int cord_width_p        = 4,
    parameter int len_width_p         = 2,
    parameter int max_payload_width_p = 40,
    localparam int packet_width_lp    = max_payload_width_p + len_width_p + cord_width_p
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic [flit_width_p+1:0]    link_i,
    output logic [flit_width_p+1:0]    link_o,
    output logic [packet_width_lp-1:0] packet_o,
    output logic                       v_o,
    input  logic                       yumi_i,
    output logic                       error_o
);

    localparam int max_flits_lp = (packet_width_lp + flit_width_p - 1) / flit_width_p;
    localparam int max_len_lp   = max_flits_lp - 1;
    localparam int buf_width_lp = max_flits_lp * flit_width_p;
    localparam int cnt_width_lp =
        ((len_width_p > $clog2(max_flits_lp)) ? len_width_p : $clog2(max_flits_lp)) + 1;
    localparam logic [cnt_width_lp-1:0] max_len_c = cnt_width_lp'(max_len_lp);

    typedef enum logic [1:0] {
        e_idle,
        e_recv,
        e_full
    } state_e;

    state_e                    state;
    logic                      ready_r;
    logic                      v_r;
    logic [cnt_width_lp-1:0]   count_r;
    logic [len_width_p-1:0]    len_r;
    logic [buf_width_lp-1:0]   buf_r;

    logic                      flit_v;
    logic [flit_width_p-1:0]   flit_data;
    logic                      flit_accept;
    logic                      hdr_accept;
    logic [len_width_p-1:0]    hdr_len;
    logic [cnt_width_lp-1:0]   hdr_len_ext;
    logic [cnt_width_lp-1:0]   len_ext;

    assign flit_v      = link_i[flit_width_p+1];
    assign flit_data   = link_i[flit_width_p:1];
    assign flit_accept = flit_v & ready_r;
    assign hdr_accept  = flit_accept & (state == e_idle);
    assign hdr_len     = flit_data[cord_width_p +: len_width_p];
    assign hdr_len_ext = cnt_width_lp'(hdr_len);
    assign len_ext     = cnt_width_lp'(len_r);

    // Flits past the buffer's last slot still count toward len but are never stored.
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            state   <= e_idle;
            ready_r <= 1'b0;
            v_r     <= 1'b0;
            count_r <= '0;
            len_r   <= '0;
            buf_r   <= '0;
        end else begin
            case (state)
                e_idle: begin
                    ready_r <= 1'b1;
                    if (flit_accept) begin
                        buf_r <= buf_width_lp'(flit_data);
                        len_r <= hdr_len;
                        if (hdr_len == '0) begin
                            state   <= e_full;
                            ready_r <= 1'b0;
                            v_r     <= 1'b1;
                        end else begin
                            count_r <= cnt_width_lp'(1);
                            state   <= e_recv;
                        end
                    end
                end
                e_recv: begin
                    if (flit_accept) begin
                        for (int s = 0; s < max_flits_lp; s++) begin
                            if (count_r == cnt_width_lp'(s)) begin
                                buf_r[s*flit_width_p +: flit_width_p] <= flit_data;
                            end
                        end
                        count_r <= count_r + cnt_width_lp'(1);
                        if (count_r == len_ext) begin
                            state   <= e_full;
                            ready_r <= 1'b0;
                            v_r     <= 1'b1;
                        end
                    end
                end
                e_full: begin
                    if (yumi_i) begin
                        state   <= e_idle;
                        ready_r <= 1'b1;
                        v_r     <= 1'b0;
                        count_r <= '0;
                    end
                end
                default: begin
                    state   <= e_idle;
                    ready_r <= 1'b0;
                    v_r     <= 1'b0;
                end
            endcase
        end
    end

    assign packet_o = buf_r[packet_width_lp-1:0];
    assign v_o      = v_r;
    assign link_o   = {1'b0, {flit_width_p{1'b0}}, ready_r};

    logic unused_signals;
    assign unused_signals = ^{link_i[0], buf_r};

`ifdef BP_ME_WH_DESER_PROTOCOL_CHECK_EN
    logic error_r;

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            error_r <= 1'b0;
        end else if ((hdr_accept && (hdr_len_ext > max_len_c)) || (yumi_i && !v_r)) begin
            error_r <= 1'b1;
        end
    end

    assign error_o = error_r;

`ifndef SYNTHESIS
    always_ff @(posedge clk_i) begin
        if (reset_i && hdr_accept) begin
            assert (hdr_len_ext <= max_len_c)
            else $warning("overlong wormhole header: cord=%0h len=%0d",
                          flit_data[cord_width_p-1:0], hdr_len);
        end
    end
`endif
`else
    assign error_o = 1'b0;
`endif

endmodule

// File: tb/tb_bp_me_wormhole_packet_deserializer.sv
// Randomized self-checking bench for bp_me_wormhole_packet_deserializer against a packet-level model.
module tb_bp_me_wormhole_packet_deserializer;

    localparam int FW = 16;
    localparam int PW = 46;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [FW+1:0] link_i = '0;
    logic [FW+1:0] link_o;
    logic [PW-1:0] packet_o;
    logic          v_o;
    logic          yumi = 1'b0;
    logic          error_o;

    int   checks = 0;
    int   passes = 0;
    bit   errExp = 1'b0;
    bit   checkEn;
    logic [15:0] txFlits[4];
    int   txCount = 0;

    bp_me_wormhole_packet_deserializer dut (
        .clk_i    (clk),
        .reset_i  (reset_n),
        .link_i   (link_i),
        .link_o   (link_o),
        .packet_o (packet_o),
        .v_o      (v_o),
        .yumi_i   (yumi),
        .error_o  (error_o)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs === exp) passes++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    // Reference: flit i lands at bit 16*i; anything beyond the 46-bit packet is lost.
    function automatic logic [PW-1:0] modelPacket();
        logic [63:0] acc = 64'd0;
        for (int i = 0; i < txCount && i < 3; i++) acc = acc | (64'(txFlits[i]) << (16 * i));
        return acc[PW-1:0];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input int gapMin, input int gapMax);
        int waited;
        for (int i = 0; i < txCount; i++) begin
            repeat ($urandom_range(gapMax, gapMin)) begin
                link_i = '0;
                tick();
            end
            link_i = {1'b1, txFlits[i], 1'b0};
            waited = 0;
            while (!link_o[0] && waited < 50) begin
                tick();
                waited++;
            end
            if (waited >= 50) begin
                checkOutput("accept_timeout", 64'd0, 64'd1);
                link_i = '0;
                return;
            end
            if (i == 0 && checkEn && (((txFlits[0] >> 4) & 16'd3) > 16'd2)) errExp = 1'b1;
            tick();
        end
        link_i = '0;
    endtask

    task automatic finishPacket(input string tag, input int holdCycles);
        logic [PW-1:0] exp;
        exp = modelPacket();
        checkOutput({tag, "_valid"}, 64'(v_o), 64'd1);
        checkOutput({tag, "_packet"}, 64'(packet_o), 64'(exp));
        checkOutput({tag, "_error"}, 64'(error_o), 64'(errExp));
        repeat (holdCycles) begin
            tick();
            checkOutput({tag, "_hold_valid"}, 64'(v_o), 64'd1);
            checkOutput({tag, "_hold_ready"}, 64'(link_o[0]), 64'd0);
            checkOutput({tag, "_hold_packet"}, 64'(packet_o), 64'(exp));
        end
        yumi = 1'b1;
        tick();
        yumi = 1'b0;
        checkOutput({tag, "_release_valid"}, 64'(v_o), 64'd0);
        checkOutput({tag, "_release_ready"}, 64'(link_o[0]), 64'd1);
    endtask

    initial begin
        logic [15:0] hdr;
        int len;
`ifdef BP_ME_WH_DESER_PROTOCOL_CHECK_EN
        checkEn = 1'b1;
`else
        checkEn = 1'b0;
`endif
        repeat (3) tick();
        checkOutput("reset_valid", 64'(v_o), 64'd0);
        checkOutput("reset_packet", 64'(packet_o), 64'd0);
        checkOutput("reset_ready", 64'(link_o[0]), 64'd0);
        checkOutput("reset_error", 64'(error_o), 64'd0);
        checkOutput("reset_link_vdata", 64'(link_o[FW+1:1]), 64'd0);
        reset_n = 1'b1;
        tick();
        checkOutput("post_reset_ready", 64'(link_o[0]), 64'd1);

        // Single-flit packet, consumer takes it two cycles late.
        txFlits[0] = 16'h0005; txCount = 1;
        applyStimulus(0, 0);
        checkOutput("single_literal", 64'(packet_o), 64'h0005);
        finishPacket("single", 2);

        // Three flits back to back, top bits of the last flit dropped.
        txFlits[0] = 16'h1125; txFlits[1] = 16'h2222; txFlits[2] = 16'hC033; txCount = 3;
        applyStimulus(0, 0);
        checkOutput("three_literal", 64'(packet_o), 64'h0033_2222_1125);

        // Backpressure: the next header waits while the full packet is unclaimed.
        link_i = {1'b1, 16'h0005, 1'b0};
        repeat (5) begin
            tick();
            checkOutput("bp_ready", 64'(link_o[0]), 64'd0);
            checkOutput("bp_valid", 64'(v_o), 64'd1);
            checkOutput("bp_packet", 64'(packet_o), 64'h0033_2222_1125);
        end
        yumi = 1'b1;
        tick();
        yumi = 1'b0;
        checkOutput("bp_bubble_valid", 64'(v_o), 64'd0);
        checkOutput("bp_bubble_ready", 64'(link_o[0]), 64'd1);
        tick();
        link_i = '0;
        txFlits[0] = 16'h0005; txCount = 1;
        finishPacket("bp_next", 0);

        // Same three flits with idle gaps between them.
        txFlits[0] = 16'h1125; txFlits[1] = 16'h2222; txFlits[2] = 16'hC033; txCount = 3;
        applyStimulus(3, 3);
        finishPacket("gaps", 1);

        // Reset partway through a len=2 packet.
        txCount = 2;
        applyStimulus(0, 0);
        reset_n = 1'b0;
        tick();
        errExp = 1'b0;
        checkOutput("midreset_valid", 64'(v_o), 64'd0);
        checkOutput("midreset_packet", 64'(packet_o), 64'd0);
        checkOutput("midreset_ready", 64'(link_o[0]), 64'd0);
        reset_n = 1'b1;
        tick();
        txFlits[0] = 16'h0007; txCount = 1;
        applyStimulus(0, 0);
        checkOutput("midreset_next_literal", 64'(packet_o), 64'h0007);
        finishPacket("midreset_next", 0);

        // Overlong header: fourth flit accepted but not stored.
        txFlits[0] = 16'h0035; txFlits[1] = 16'hAAAA; txFlits[2] = 16'h5555; txFlits[3] = 16'hFFFF;
        txCount = 4;
        applyStimulus(0, 1);
        checkOutput("overlong_literal", 64'(packet_o), 64'h1555_AAAA_0035);
        finishPacket("overlong", 1);

        // Random packets with random gaps and consumer delays.
        for (int p = 0; p < 40; p++) begin
            hdr = 16'($urandom);
            len = int'((hdr >> 4) & 16'd3);
            txFlits[0] = hdr;
            for (int i = 1; i <= len; i++) txFlits[i] = 16'($urandom);
            txCount = len + 1;
            applyStimulus(0, 2);
            finishPacket("random", int'($urandom_range(3, 0)));
        end

        // Stray yumi with nothing valid is ignored (but flagged when checking is built in).
        yumi = 1'b1;
        tick();
        yumi = 1'b0;
        if (checkEn) errExp = 1'b1;
        checkOutput("stray_yumi_valid", 64'(v_o), 64'd0);
        checkOutput("stray_yumi_ready", 64'(link_o[0]), 64'd1);
        tick();
        checkOutput("stray_yumi_error", 64'(error_o), 64'(errExp));

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/bp_me_wormhole_packet_deserializer.md
Name: bp_me_wormhole_packet_deserializer

Overview:
- Receive endpoint of a coherence-NoC ready_and wormhole link; reassembles flits into one wormhole packet of {payload, len, cord}.
- Counterpart of the tile-side transmit adapters that serialize encoded LCE req/cmd/resp packets.
- Sits between a concentrator or router port and a consumer (I/O CCE, accelerator LCE) that takes packet_o with a v/yumi handshake.
- The consumer extracts the payload field of packet_o.

Parameters:
- flit_width_p, 16, link flit width in bits.
- cord_width_p, 4, destination coordinate field width; packet bits [cord_width_p-1:0].
- len_width_p, 2, length field width; packet bits [cord_width_p+len_width_p-1:cord_width_p]. Value is the number of flits after the header.
- max_payload_width_p, 40, payload width above the len field.
- Derived packet_width_lp = max_payload_width_p + len_width_p + cord_width_p.
- Derived max_flits_lp = ceil(packet_width_lp / flit_width_p).
- Derived max_len_lp = max_flits_lp - 1.

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  synchronous, active-low reset.
- link_i  in  flit_width_p+2  ready_and link: {v[MSB], data[flit_width_p-1:0], ready_and_rev[LSB]}. ready_and_rev is ignored.
- link_o  out  flit_width_p+2  same layout; v and data are tied 0, ready_and_rev is this block's ready.
- packet_o  out  packet_width_lp  assembled packet.
- v_o  out  1  packet_o valid.
- yumi_i  in  1  consumer takes the packet; legal only when v_o=1.
- error_o  out  1  protocol error, sticky. See Optional Feature.

Behaviour:
- Flit accept: a flit is accepted when link_i.v=1 and ready=1 in the same cycle.
- Reset (reset_i=0 at a clk_i edge):
  - state=IDLE, v_o=0, packet_o=0, ready=0, counter=0, error_o=0.
  - Any partial packet is discarded.
  - ready rises the first cycle after reset deasserts.
- States: IDLE, RECV, FULL.
- IDLE:
  - ready=1.
  - On header accept: clear buffer, write flit to slot 0, latch len = header[cord_width_p+len_width_p-1:cord_width_p].
  - len=0 -> FULL; else counter=1 -> RECV.
- RECV:
  - ready=1.
  - Each accepted flit is written to slot counter (bits [counter*flit_width_p +: flit_width_p]), then counter++.
  - When the flit with counter==len is accepted -> FULL.
  - link_i.v gaps are allowed at any point; state holds.
- FULL:
  - v_o=1, ready=0.
  - packet_o is the buffer truncated to packet_width_lp; bits of the last flit above packet_width_lp are dropped.
  - Slots never written read 0.
  - packet_o and v_o are stable until yumi_i.
  - On yumi_i -> IDLE. ready=1 the next cycle (one-cycle bubble, no same-cycle bypass).
- Latency: v_o=1 the cycle after the final flit is accepted. A single-flit packet accepted at cycle N gives v_o=1 at cycle N+1.
- Throughput: 1 flit/cycle within a packet; a minimum of 1 idle cycle between packets.
- len > max_len_lp:
  - Flits with index > max_len_lp are accepted and discarded (not written).
  - The packet completes after len+1 flits total.
  - Counter width is max(len_width_p, clog2(max_flits_lp)) + 1, so it does not wrap.
- yumi_i while v_o=0: ignored.
- Width rules: all slot indices are unsigned; no arithmetic on data bits.

Optional Feature:
- Macro: BP_ME_WH_DESER_PROTOCOL_CHECK_EN.
- Defined:
  - error_o sets to 1 on a header with len > max_len_lp, or on yumi_i while v_o=0. It clears only on reset.
  - A simulation-only assertion prints the cord and len of the offending header.
- Undefined:
  - error_o is tied 0; no check logic.
  - Overlong-packet discard behaviour is identical in both builds.

Test Plan (defaults: packet_width_lp=46, max_flits_lp=3, max_len_lp=2):
- Single flit: header 16'h0005 (cord=5, len=0) at cycle N -> v_o=1 at N+1, packet_o=46'h0005. yumi_i at N+3 -> v_o=0 and ready=1 at N+4.
- Three flits: 16'h1125 (len=2), 16'h2222, 16'hC033 back-to-back -> packet_o=46'h0033_2222_1125 (top 2 bits of 0xC033 dropped). v_o=1 the cycle after the third flit.
- Backpressure: yumi_i held 0 for 5 cycles while link_i.v=1 with a next header:
  - Required: ready=0, packet_o and v_o unchanged, header not consumed.
  - After yumi_i: the header is accepted on the 2nd cycle.
- Gaps: the three-flit packet with link_i.v=0 for 3 cycles between flits -> same packet_o as the three-flit case, no extra or lost flits.
- Reset mid-packet: reset_i=0 after the 2nd flit of a len=2 packet:
  - Required: v_o=0, packet_o=0.
  - Then a header 16'h0007 (len=0) -> packet_o=46'h0007; no residue from the discarded packet.
- Overlong header 16'h0035 (len=3) plus 3 more flits:
  - All 4 flits accepted; packet_o = first 3 flits.
  - error_o=1 with the macro, 0 without.
